fpu_result_buffer: RTL and testbench
====================================

Name: fpu_result_buffer

Overview:
- Downstream stage of the FPU adder. Captures each completed result word `{sign, exp[5:0], mant[24:0]}` together with its 4-bit status into a show-ahead FIFO for the consumer (display/test logic).
- Keeps sticky status flags and per-status event counters, so bursts of FPU results are not lost when the consumer is slow.
- Sits between the FPU outputs and any readout logic; it is the FPU's only result sink.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of each status event counter.

Ports:
- clock100KHz  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- res_data_in  in  32  FPU result word.
- res_status_in  in  4  FPU status, one-hot: bit0 EXACT, bit1 INEXACT, bit2 OVERFLOW, bit3 UNDERFLOW.
- res_valid_in  in  1  result word/status valid this cycle.
- res_ready_out  out  1  buffer can accept this cycle; equals not-full.
- rd_en_in  in  1  consumer pops the head entry.
- rd_data_out  out  32  head entry data; zero when empty.
- rd_status_out  out  4  head entry status; zero when empty.
- rd_valid_out  out  1  FIFO not empty.
- level_out  out  $clog2(DEPTH)+1  number of entries held.
- sticky_out  out  4  OR of all accepted statuses since the last clear.
- clear_in  in  1  synchronous clear of sticky flags and counters.
- err_out  out  1  sticky flag: a status that was not one-hot was accepted, or a push was dropped.

Behaviour:
- Reset, asynchronous and active-high: pointers 0, level 0, rd_valid_out 0, rd_data_out 0, rd_status_out 0, res_ready_out 1, sticky_out 0, err_out 0, all counters 0.
- Accept condition: res_valid_in & res_ready_out.
  - The entry is written at the tail on that edge.
  - Latency to rd_valid_out high on an empty FIFO is 1 cycle.
- Pop condition: rd_en_in & rd_valid_out.
  - The head advances on that edge.
  - rd_en_in while empty is ignored, with no error.
- Show-ahead read: rd_data_out and rd_status_out are combinational from the head entry, gated to zero when empty.
- Simultaneous push and pop:
  - Not full and not empty: both happen and the level is unchanged.
  - Empty: the push happens; the pop is ignored.
  - Full: res_ready_out is 0, so only the pop happens. The producer sees ready again next cycle.
- res_valid_in while full: the word is dropped and err_out is set. The FPU has no back-pressure, so this is the overflow case.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Level is tracked separately so full and empty are unambiguous.
- Status check on each accept:
  - sticky_out |= res_status_in.
  - If res_status_in is not exactly one-hot (zero or multiple bits set), err_out is set. The entry is still stored.
- Read-side state machine (IDLE, HOLD):
  - IDLE: level 0. Goes to HOLD on accept.
  - HOLD: level > 0. Goes to IDLE when a pop empties the FIFO with no simultaneous push.
  - rd_valid_out = (state == HOLD).
- clear_in:
  - Zeroes sticky_out, err_out and the counters.
  - If an accept occurs in the same cycle, the result reflects only that new entry, i.e. clear is applied first, then set.
  - clear_in does not flush the FIFO.
- Reset asserted mid-burst: the FIFO contents are discarded immediately. Stored data cells need not be cleared, but the outputs are gated to zero.

Optional Feature:
- Macro: FPU_RESULT_CNT_EN.
- When defined, four extra output ports are present: cnt_exact_out, cnt_inexact_out, cnt_ovf_out, cnt_unf_out, each CNT_W bits.
  - Each increments by 1 on an accept whose one-hot status bit is set.
  - Each saturates at all-ones and never wraps.
  - Each is zeroed by reset and by clear_in.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package fpu_pkg:
  - Status bit index constants: ST_EXACT=0, ST_INEXACT=1, ST_OVF=2, ST_UNF=3.
  - Field widths: EXP_W=6, MANT_W=25, BIAS=31.
  - A typedef for the 32-bit result word with sign/exp/mant fields.
  - The read-side state enum.
- One sub-module, fpu_result_fifo: a generic DEPTH x 36 show-ahead FIFO with push/pop/level. The top level adds the status logic, sticky flags, err flag and optional counters.

Test Plan:
- Reset, then push 0x3E000000 with status 0001 → next cycle rd_valid_out=1, rd_data_out=0x3E000000, rd_status_out=0001, level_out=1, sticky_out=0001.
- Push 8 words without popping → after the 8th, res_ready_out=0. A 9th valid word is dropped: err_out=1, level_out stays 8, and entries read back in order.
- At level 3, assert push and pop in the same cycle → level_out stays 3, head advances. On an empty FIFO, push+pop gives level_out=1.
- Push statuses 0010 then 0100 → sticky_out=0110. A push with status 0011 sets err_out=1. clear_in together with a push of 1000 gives sticky_out=1000, err_out=0.
- Assert reset asynchronously mid-burst, between clock edges → outputs go to zero before the next edge: rd_valid_out=0, level_out=0, res_ready_out=1.
- With FPU_RESULT_CNT_EN and CNT_W=2, push 5 EXACT results → cnt_exact_out saturates at 3; the other counters stay 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU result buffer: status bit indices, result word
// field widths, the packed result word type and the read-side state encoding.
package fpu_pkg;

    // Bit positions within the 4-bit one-hot FPU status.
    localparam int unsigned ST_EXACT   = 0;
    localparam int unsigned ST_INEXACT = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_UNF     = 3;

    // Result word layout: {sign, exp[5:0], mant[24:0]}.
    localparam int unsigned EXP_W  = 6;
    localparam int unsigned MANT_W = 25;
    localparam int unsigned BIAS   = 31;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fpu_word_t;

    // Read side: StIdle while empty, StHold while at least one entry is held.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } rd_state_e;

    // True when exactly one status bit is set.
    function automatic logic is_one_hot4(input logic [3:0] s);
        return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Generic show-ahead FIFO, DEPTH x WIDTH.
// Ports:
//   clk_i, rst_i   clock (rising edge) and asynchronous active-high reset
//   push_i         write wdata_i at the tail (caller guarantees not full)
//   pop_i          advance the head (caller guarantees not empty)
//   wdata_i        write data
//   rdata_o        head entry, raw (not gated; caller masks when empty)
//   level_o        number of entries held, 0..DEPTH
//   full_o         level_o == DEPTH
module fpu_result_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 36
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    // Pointers wrap naturally because DEPTH is a power of two; the separate
    // level counter disambiguates full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            level_d = level_q + 1'b1;
        end else if (pop_i && !push_i) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage cells are not reset; the outputs are masked upstream instead.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/fpu_result_buffer.sv
// FPU result buffer: captures each FPU result word and its status into a
// show-ahead FIFO, keeps sticky status flags and an error flag, and (with
// FPU_RESULT_CNT_EN defined) saturating per-status event counters.
// Ports:
//   clock100KHz, reset        clock (rising edge), asynchronous active-high reset
//   res_data_in/status/valid  FPU result word, one-hot status, valid
//   res_ready_out             buffer not full
//   rd_en_in                  consumer pops the head entry
//   rd_data_out/status_out    head entry, zero when empty
//   rd_valid_out              FIFO not empty
//   level_out                 entries held
//   sticky_out                OR of accepted statuses since last clear
//   clear_in                  synchronous clear of sticky, err and counters
//   err_out                   sticky: non-one-hot status accepted or push dropped
//   cnt_*_out                 saturating status counters (FPU_RESULT_CNT_EN only)
module fpu_result_buffer
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clock100KHz,
    input  logic                   reset,
    input  logic [31:0]            res_data_in,
    input  logic [3:0]             res_status_in,
    input  logic                   res_valid_in,
    output logic                   res_ready_out,
    input  logic                   rd_en_in,
    output logic [31:0]            rd_data_out,
    output logic [3:0]             rd_status_out,
    output logic                   rd_valid_out,
    output logic [$clog2(DEPTH):0] level_out,
    output logic [3:0]             sticky_out,
    input  logic                   clear_in,
    output logic                   err_out
`ifdef FPU_RESULT_CNT_EN
    ,
    output logic [CNT_W-1:0]       cnt_exact_out,
    output logic [CNT_W-1:0]       cnt_inexact_out,
    output logic [CNT_W-1:0]       cnt_ovf_out,
    output logic [CNT_W-1:0]       cnt_unf_out
`endif
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_params
        $error("fpu_result_buffer: DEPTH must be a power of two >= 2, CNT_W >= 1");
    end

    rd_state_e state_q;
    logic      full;
    logic      accept;
    logic      pop;
    logic      drop;
    logic [35:0] head;
    fpu_word_t   word_in;
    logic [3:0]  sticky_q, sticky_d;
    logic        err_q, err_d;

    assign word_in  = res_data_in;
    assign accept   = res_valid_in & ~full;
    assign drop     = res_valid_in & full;
    // rd_valid_out comes from the state register, so popping while empty is a no-op.
    assign pop      = rd_en_in & rd_valid_out;

    fpu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (36)
    ) u_fifo (
        .clk_i   (clock100KHz),
        .rst_i   (reset),
        .push_i  (accept),
        .pop_i   (pop),
        .wdata_i ({res_status_in, word_in}),
        .rdata_o (head),
        .level_o (level_out),
        .full_o  (full)
    );

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (accept) state_q <= StHold;
                StHold: if (pop && !accept && level_out == LW'(1)) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd_valid_out  = (state_q == StHold);
    assign res_ready_out = ~full;
    assign rd_data_out   = rd_valid_out ? head[31:0]  : 32'd0;
    assign rd_status_out = rd_valid_out ? head[35:32] : 4'd0;

    // Clear first, then set: an accept in the clear cycle survives.
    always_comb begin
        sticky_d = clear_in ? 4'd0 : sticky_q;
        err_d    = clear_in ? 1'b0 : err_q;
        if (accept) begin
            sticky_d = sticky_d | res_status_in;
            if (!is_one_hot4(res_status_in)) begin
                err_d = 1'b1;
            end
        end
        if (drop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            sticky_q <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            err_q    <= err_d;
        end
    end

    assign sticky_out = sticky_q;
    assign err_out    = err_q;

`ifdef FPU_RESULT_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = clear_in ? '0 : cnt_q[i];
            if (accept && res_status_in[i] && cnt_d[i] != '1) begin
                cnt_d[i] = cnt_d[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cnt_exact_out   = cnt_q[ST_EXACT];
    assign cnt_inexact_out = cnt_q[ST_INEXACT];
    assign cnt_ovf_out     = cnt_q[ST_OVF];
    assign cnt_unf_out     = cnt_q[ST_UNF];
`endif

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Self-checking bench for fpu_result_buffer: directed vector table, hand-written
// full/overflow and asynchronous-reset sequences, and randomized traffic against
// a queue-based reference model.
module tb_fpu_result_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   res_data;
    logic [3:0]    res_status;
    logic          res_valid;
    logic          res_ready;
    logic          rd_en;
    logic [31:0]   rd_data;
    logic [3:0]    rd_status;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic [3:0]    sticky;
    logic          clear;
    logic          err;
`ifdef FPU_RESULT_CNT_EN
    logic [CNT_W-1:0] cnt_exact, cnt_inexact, cnt_ovf, cnt_unf;
`endif

    always #5 clk = ~clk;

    fpu_result_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock100KHz   (clk),
        .reset         (rst),
        .res_data_in   (res_data),
        .res_status_in (res_status),
        .res_valid_in  (res_valid),
        .res_ready_out (res_ready),
        .rd_en_in      (rd_en),
        .rd_data_out   (rd_data),
        .rd_status_out (rd_status),
        .rd_valid_out  (rd_valid),
        .level_out     (level),
        .sticky_out    (sticky),
        .clear_in      (clear),
        .err_out       (err)
`ifdef FPU_RESULT_CNT_EN
        ,
        .cnt_exact_out   (cnt_exact),
        .cnt_inexact_out (cnt_inexact),
        .cnt_ovf_out     (cnt_ovf),
        .cnt_unf_out     (cnt_unf)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: entries as a queue, flags and counters as plain values.
    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;
    ent_t       mq[$];
    logic [3:0] m_sticky;
    logic       m_err;
    int         m_cnt[4];

    typedef struct {
        logic        v;
        logic [3:0]  st;
        logic [31:0] d;
        logic        rd;
        logic        clr;
        int          lvl;
        logic        val;
        logic [31:0] hd;
        logic [3:0]  hs;
        logic [3:0]  stk;
        logic        er;
    } vec_t;
    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_sticky = 4'd0;
        m_err    = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    // Drive one cycle of stimulus, advance the model, then sample 1 ns after the edge.
    task automatic apply(input logic v, input logic [3:0] st, input logic [31:0] d,
                         input logic rd, input logic clr);
        bit ready, acc, pp;
        ent_t e;
        res_valid  = v;
        res_status = st;
        res_data   = d;
        rd_en      = rd;
        clear      = clr;
        ready = (mq.size() < DEPTH);
        acc   = v && ready;
        pp    = rd && (mq.size() > 0);
        if (clr) begin
            m_sticky = 4'd0;
            m_err    = 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end
        if (pp) void'(mq.pop_front());
        if (acc) begin
            e.d = d;
            e.s = st;
            mq.push_back(e);
            m_sticky = m_sticky | st;
            if ($countones(st) != 1) m_err = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (st[i] && m_cnt[i] < CMAX) m_cnt[i]++;
            end
        end
        if (v && !ready) m_err = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] ed;
        logic [3:0]  es;
        ed = (mq.size() > 0) ? mq[0].d : 32'd0;
        es = (mq.size() > 0) ? mq[0].s : 4'd0;
        chk({tag, " level"},  32'(level),     32'(mq.size()));
        chk({tag, " valid"},  32'(rd_valid),  32'(mq.size() > 0));
        chk({tag, " ready"},  32'(res_ready), 32'(mq.size() < DEPTH));
        chk({tag, " data"},   rd_data,        ed);
        chk({tag, " status"}, 32'(rd_status), 32'(es));
        chk({tag, " sticky"}, 32'(sticky),    32'(m_sticky));
        chk({tag, " err"},    32'(err),       32'(m_err));
`ifdef FPU_RESULT_CNT_EN
        chk({tag, " cnt_exact"},   32'(cnt_exact),   32'(m_cnt[0]));
        chk({tag, " cnt_inexact"}, 32'(cnt_inexact), 32'(m_cnt[1]));
        chk({tag, " cnt_ovf"},     32'(cnt_ovf),     32'(m_cnt[2]));
        chk({tag, " cnt_unf"},     32'(cnt_unf),     32'(m_cnt[3]));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  st;
        logic [31:0] fill[DEPTH];

        //          v     st       data          rd    clr   lvl val  head          hs       stk      err
        vecs[0]  = '{1'b1, 4'b0001, 32'h3E000000, 1'b0, 1'b0, 1, 1'b1, 32'h3E000000, 4'b0001, 4'b0001, 1'b0};
        vecs[1]  = '{1'b1, 4'b0010, 32'h11111111, 1'b0, 1'b0, 2, 1'b1, 32'h3E000000, 4'b0001, 4'b0011, 1'b0};
        vecs[2]  = '{1'b1, 4'b0100, 32'h22222222, 1'b0, 1'b0, 3, 1'b1, 32'h3E000000, 4'b0001, 4'b0111, 1'b0};
        vecs[3]  = '{1'b1, 4'b0001, 32'h33333333, 1'b1, 1'b0, 3, 1'b1, 32'h11111111, 4'b0010, 4'b0111, 1'b0};
        vecs[4]  = '{1'b1, 4'b0011, 32'h44444444, 1'b0, 1'b0, 4, 1'b1, 32'h11111111, 4'b0010, 4'b0111, 1'b1};
        vecs[5]  = '{1'b1, 4'b1000, 32'h55555555, 1'b0, 1'b1, 5, 1'b1, 32'h11111111, 4'b0010, 4'b1000, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 4, 1'b1, 32'h22222222, 4'b0100, 4'b1000, 1'b0};
        vecs[7]  = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 3, 1'b1, 32'h33333333, 4'b0001, 4'b1000, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 2, 1'b1, 32'h44444444, 4'b0011, 4'b1000, 1'b0};
        vecs[9]  = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1, 1'b1, 32'h55555555, 4'b1000, 4'b1000, 1'b0};
        vecs[10] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 0, 1'b0, 32'h00000000, 4'b0000, 4'b1000, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 0, 1'b0, 32'h00000000, 4'b0000, 4'b1000, 1'b0};
        vecs[12] = '{1'b1, 4'b0001, 32'h66666666, 1'b1, 1'b0, 1, 1'b1, 32'h66666666, 4'b0001, 4'b1001, 1'b0};
        vecs[13] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 0, 1'b0, 32'h00000000, 4'b0000, 4'b1001, 1'b0};
        vecs[14] = '{1'b1, 4'b0000, 32'h77777777, 1'b0, 1'b0, 1, 1'b1, 32'h77777777, 4'b0000, 4'b1001, 1'b1};
        vecs[15] = '{1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b1, 0, 1'b0, 32'h00000000, 4'b0000, 4'b0000, 1'b0};

        rst = 1'b1; res_valid = 1'b0; res_status = 4'd0; res_data = 32'd0;
        rd_en = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_model("reset");

        // Directed table: explicit expectations (model kept in step).
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].v, vecs[i].st, vecs[i].d, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d level", i),  32'(level),     32'(vecs[i].lvl));
            chk($sformatf("vec%0d valid", i),  32'(rd_valid),  32'(vecs[i].val));
            chk($sformatf("vec%0d data", i),   rd_data,        vecs[i].hd);
            chk($sformatf("vec%0d status", i), 32'(rd_status), 32'(vecs[i].hs));
            chk($sformatf("vec%0d sticky", i), 32'(sticky),    32'(vecs[i].stk));
            chk($sformatf("vec%0d err", i),    32'(err),       32'(vecs[i].er));
            chk($sformatf("vec%0d ready", i),  32'(res_ready), 32'd1);
        end

        // Fill to full, drop a 9th word, push+pop at full, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            fill[i] = $urandom;
            apply(1'b1, 4'b0010, fill[i], 1'b0, 1'b0);
        end
        chk("full ready", 32'(res_ready), 32'd0);
        chk("full err_before_drop", 32'(err), 32'd0);
        apply(1'b1, 4'b0001, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("drop err", 32'(err), 32'd1);
        chk("drop level", 32'(level), 32'(DEPTH));
        apply(1'b1, 4'b0001, 32'hCAFEF00D, 1'b1, 1'b0);
        chk("full pushpop level", 32'(level), 32'(DEPTH - 1));
        chk("full pushpop ready", 32'(res_ready), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            chk($sformatf("drain%0d data", i), rd_data, fill[i]);
            apply(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        end
        check_model("drained");

        // Asynchronous reset between edges, mid-burst.
        apply(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) apply(1'b1, 4'b0100, $urandom, 1'b0, 1'b0);
        check_model("preburst");
        #3 rst = 1'b1;
        #1;
        chk("async valid", 32'(rd_valid), 32'd0);
        chk("async level", 32'(level), 32'd0);
        chk("async ready", 32'(res_ready), 32'd1);
        chk("async data", rd_data, 32'd0);
        chk("async sticky", 32'(sticky), 32'd0);
        model_reset();
        res_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_model("post_reset");

`ifdef FPU_RESULT_CNT_EN
        for (int i = 0; i < 5; i++) apply(1'b1, 4'b0001, $urandom, 1'b1, 1'b0);
        chk("sat cnt_exact", 32'(cnt_exact), 32'(CMAX));
        chk("sat cnt_inexact", 32'(cnt_inexact), 32'd0);
        check_model("sat");
`endif

        // Randomized traffic: slow consumer first (reaches full), then fast.
        for (int c = 0; c < 400; c++) begin
            int r;
            r  = $urandom_range(0, 9);
            st = (r < 8) ? (4'b0001 << (r % 4)) : 4'($urandom);
            apply(($urandom_range(0, 9) < 6), st, $urandom,
                  ($urandom_range(0, 9) < ((c < 200) ? 3 : 7)),
                  ($urandom_range(0, 99) < 3));
            check_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
